dmem_arb: RTL and testbench
===========================

Name: dmem_arb

Overview:
- Shares the single-port data memory between the processing unit's load/store port and an external host port (loader / debug / DMA).
- Grants at most one access per cycle and stalls the loser.
- Uses round-robin arbitration on conflict, plus an optional host burst-lock with a forced-release limit.
- Sits between the PU datapath (ALU address, register-file write data, dmem write enable) and the data memory.

Parameters:
- AW, 8, memory word-address width
- DW, 32, data width
- MAXBURST, 8, maximum consecutive locked host grants before forced release (range 1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pu_req  in  1  PU requests a memory access this cycle
- pu_we  in  1  PU access is a write
- pu_addr  in  AW  PU address
- pu_wd  in  DW  PU write data
- pu_stall  out  1  PU request not granted this cycle; PU must hold its request
- pu_rd  out  DW  PU read data (registered)
- pu_rvalid  out  1  pu_rd valid (one cycle)
- hs_req  in  1  host requests access
- hs_we  in  1  host access is a write
- hs_lock  in  1  host asks to keep the grant on following cycles
- hs_addr  in  AW  host address
- hs_wd  in  DW  host write data
- hs_gnt  out  1  host request granted this cycle
- hs_rd  out  DW  host read data (registered)
- hs_rvalid  out  1  hs_rd valid (one cycle)
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wd  out  DW  memory write data
- m_rd  in  DW  memory read data (combinational from m_addr)

Behaviour:
- Reset (rst=0, asynchronous): state=ARB, last=1 (host), burst counter=0, pu_rd=0, hs_rd=0, pu_rvalid=0, hs_rvalid=0.
- Combinational outputs during reset: pu_stall=pu_req, hs_gnt=0, m_we=0.
- Grant is decided combinationally in the same cycle as the request.
  - m_addr, m_wd and m_we come from the granted requester.
  - With no grant: m_we=0, m_addr=0, m_wd=0.
- pu_stall = pu_req & ~pu_grant. hs_gnt = host grant.
- A non-requesting port never receives a grant.
- State ARB:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last is granted.
  - last updates to the granted port on every grant; it holds when there is no grant.
  - Host granted with hs_lock=1: go to LOCK, counter=1.
- State LOCK:
  - Host has absolute priority; PU stalls whenever pu_req=1.
  - hs_req=1 and hs_lock=1: host is granted and the counter increments.
  - Host granted while the counter equals MAXBURST: the grant is given, then forced to ARB with last=1, so the PU wins the next conflict.
  - hs_lock=0: return to ARB this cycle; the current cycle is arbitrated as ARB.
  - hs_req=1 with hs_lock=0: the host is still eligible under ARB rules in that cycle.
  - hs_req=0 while in LOCK: no host grant; the PU may be granted; return to ARB.
- Read return:
  - A granted read (we=0) registers m_rd into the requester's rd register at the clock edge.
  - The requester's rvalid is asserted for exactly the next cycle.
  - The rd register holds its value otherwise.
  - Granted writes produce no rvalid.
- Writes commit at the clock edge of the grant cycle (memory-side behaviour); latency 0 for the grant, 1 for read data.
- Each granted access occupies exactly one cycle. A stalled PU keeps pu_req/pu_addr/pu_we/pu_wd stable; the arbiter does not latch them.
- Reset mid-LOCK:
  - Immediately returns to ARB.
  - Clears the counter and both rvalids.
  - An in-flight read's data is discarded.
- Counter saturates logically at MAXBURST (forced exit); it never wraps.

Test Plan:
- PU only: pu_req=1, pu_we=0, pu_addr=0x10, m_rd=0xDEADBEEF -> pu_stall=0, m_addr=0x10, m_we=0; next cycle pu_rvalid=1, pu_rd=0xDEADBEEF; hs_rvalid stays 0.
- Conflict right after reset: both read at 0x01/0x02 -> cycle1 PU granted (hs_gnt=0); cycle2 host granted, pu_stall=1; cycle3 PU granted; alternation continues.
- Host write: hs_req=1, hs_we=1, hs_addr=0x20, hs_wd=0x55 -> hs_gnt=1, m_we=1, m_addr=0x20, m_wd=0x55; no hs_rvalid next cycle.
- Burst limit, MAXBURST=4: host lock with PU requesting continuously -> hs_gnt=1 for exactly 4 cycles with pu_stall=1; cycle 5 PU granted even though hs_req=hs_lock=1.
- Early lock release: lock for 2 grants, then hs_lock=0 with both requesting -> the same cycle is arbitrated as ARB; PU granted (last=host).
- Async reset during LOCK after 2 grants: rst=0 mid-cycle -> hs_gnt=0, m_we=0 immediately; rvalids 0; after release, a conflict grants PU first.

Source files
------------

// File: rtl/dmem_arb.sv
// dmem_arb
// Shares the single-port data memory between the processing unit's
// load/store port and an external host port (loader / debug / DMA).
// At most one access is granted per cycle. The losing requester is stalled.
// Conflicts are settled round-robin.
// The host may lock the memory for a burst of consecutive grants. The burst
// is forcibly released after MAXBURST grants.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   pu_req/pu_we/pu_addr/pu_wd     PU access request
//   pu_stall                       PU request not granted this cycle
//   pu_rd/pu_rvalid                registered PU read data, valid one cycle
//   hs_req/hs_we/hs_lock/hs_addr/hs_wd  host access request, lock hint
//   hs_gnt                         host request granted this cycle
//   hs_rd/hs_rvalid                registered host read data, valid one cycle
//   m_we/m_addr/m_wd/m_rd          data memory port (m_rd combinational)
module dmem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAXBURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pu_req,
  input  logic          pu_we,
  input  logic [AW-1:0] pu_addr,
  input  logic [DW-1:0] pu_wd,
  output logic          pu_stall,
  output logic [DW-1:0] pu_rd,
  output logic          pu_rvalid,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic          hs_lock,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wd,
  output logic          hs_gnt,
  output logic [DW-1:0] hs_rd,
  output logic          hs_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAXBURST);

  state_t     state;
  logic       last;        // 1 = host was granted most recently
  logic [7:0] cnt;         // locked host grants so far in the current burst
  logic [7:0] burst_next;  // burst length including this cycle's grant
  logic       lock_hold;   // LOCK state and host still asking to keep it
  logic       pu_grant;
  logic       hs_grant;

  // Grant decision. The host keeps the memory outright only while locked and
  // still requesting with the lock. Every other case, including the cycle a
  // lock is dropped, uses round-robin rules. Nothing is granted during reset.
  always_comb begin
    pu_grant  = 1'b0;
    hs_grant  = 1'b0;
    lock_hold = (state == LOCK) && hs_req && hs_lock;
    if (rst) begin
      if (lock_hold) begin
        hs_grant = 1'b1;
      end else if (pu_req && hs_req) begin
        if (last) pu_grant = 1'b1;
        else      hs_grant = 1'b1;
      end else if (pu_req) begin
        pu_grant = 1'b1;
      end else if (hs_req) begin
        hs_grant = 1'b1;
      end
    end
    burst_next = lock_hold ? cnt + 8'd1 : 8'd1;
  end

  assign pu_stall = pu_req & ~pu_grant;
  assign hs_gnt   = hs_grant;

  // The memory port follows the granted requester. It is zeroed when idle.
  always_comb begin
    m_we   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    if (pu_grant) begin
      m_we   = pu_we;
      m_addr = pu_addr;
      m_wd   = pu_wd;
    end else if (hs_grant) begin
      m_we   = hs_we;
      m_addr = hs_addr;
      m_wd   = hs_wd;
    end
  end

  // Lock FSM, round-robin pointer and read-return registers.
  // A locked host grant that brings the burst to MAXBURST drops back to ARB.
  // last is then left at host, so the PU wins the next conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      last      <= 1'b1;
      cnt       <= 8'd0;
      pu_rd     <= '0;
      hs_rd     <= '0;
      pu_rvalid <= 1'b0;
      hs_rvalid <= 1'b0;
    end else begin
      pu_rvalid <= pu_grant && !pu_we;
      hs_rvalid <= hs_grant && !hs_we;
      if (pu_grant && !pu_we) pu_rd <= m_rd;
      if (hs_grant && !hs_we) hs_rd <= m_rd;

      if (pu_grant)      last <= 1'b0;
      else if (hs_grant) last <= 1'b1;

      if (hs_grant && hs_lock && (burst_next < MAX_CNT)) begin
        state <= LOCK;
        cnt   <= burst_next;
      end else begin
        state <= ARB;
        cnt   <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb
// Directed test of dmem_arb with MAXBURST = 4.
// A small behavioural memory answers m_rd. Unwritten words read as
// {8'hA5, 16'h0, addr}. Word 0x10 is preloaded with 0xDEADBEEF.
module tb_dmem_arb;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pu_req, pu_we;
  logic [AW-1:0] pu_addr;
  logic [DW-1:0] pu_wd;
  logic          pu_stall;
  logic [DW-1:0] pu_rd;
  logic          pu_rvalid;
  logic          hs_req, hs_we, hs_lock;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wd;
  logic          hs_gnt;
  logic [DW-1:0] hs_rd;
  logic          hs_rvalid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;

  int passCount  = 0;
  int checkCount = 0;

  bit [DW-1:0] mem     [256];
  bit          written [256];

  dmem_arb #(.AW(AW), .DW(DW), .MAXBURST(4)) dut (
    .clk(clk), .rst(rst),
    .pu_req(pu_req), .pu_we(pu_we), .pu_addr(pu_addr), .pu_wd(pu_wd),
    .pu_stall(pu_stall), .pu_rd(pu_rd), .pu_rvalid(pu_rvalid),
    .hs_req(hs_req), .hs_we(hs_we), .hs_lock(hs_lock), .hs_addr(hs_addr),
    .hs_wd(hs_wd), .hs_gnt(hs_gnt), .hs_rd(hs_rd), .hs_rvalid(hs_rvalid),
    .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  always_comb begin
    if (written[m_addr])       m_rd = mem[m_addr];
    else if (m_addr == 8'h10)  m_rd = 32'hDEADBEEF;
    else                       m_rd = {8'hA5, 16'h0000, m_addr};
  end

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_addr]     <= m_wd;
      written[m_addr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else passCount++;
  endtask

  task automatic applyStimulus(input logic preq, input logic pwe, input logic [AW-1:0] paddr,
                               input logic [DW-1:0] pwd, input logic hreq, input logic hwe,
                               input logic hlock, input logic [AW-1:0] haddr,
                               input logic [DW-1:0] hwd);
    pu_req = preq; pu_we = pwe; pu_addr = paddr; pu_wd = pwd;
    hs_req = hreq; hs_we = hwe; hs_lock = hlock; hs_addr = haddr; hs_wd = hwd;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0);
    #2;
    // During reset: no grants, a requesting PU is stalled.
    checkOutput("rst_pu_stall", pu_stall, 1);
    checkOutput("rst_hs_gnt", hs_gnt, 0);
    checkOutput("rst_m_we", m_we, 0);
    checkOutput("rst_pu_rvalid", pu_rvalid, 0);
    checkOutput("rst_hs_rvalid", hs_rvalid, 0);
    checkOutput("rst_pu_rd", pu_rd, 0);
    checkOutput("rst_hs_rd", hs_rd, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10 rst = 1'b1;

    // Conflict right after reset: last=host, so the PU goes first.
    nextCycle();
    applyStimulus(1, 0, 8'h01, 0, 1, 0, 0, 8'h02, 0);
    #1;
    checkOutput("cf1_hs_gnt", hs_gnt, 0);
    checkOutput("cf1_pu_stall", pu_stall, 0);
    checkOutput("cf1_m_addr", m_addr, 8'h01);
    nextCycle();
    checkOutput("cf2_pu_rvalid", pu_rvalid, 1);
    checkOutput("cf2_pu_rd", pu_rd, 32'hA5000001);
    checkOutput("cf2_hs_gnt", hs_gnt, 1);
    checkOutput("cf2_pu_stall", pu_stall, 1);
    checkOutput("cf2_m_addr", m_addr, 8'h02);
    nextCycle();
    checkOutput("cf3_hs_rvalid", hs_rvalid, 1);
    checkOutput("cf3_hs_rd", hs_rd, 32'hA5000002);
    checkOutput("cf3_pu_rvalid", pu_rvalid, 0);
    checkOutput("cf3_hs_gnt", hs_gnt, 0);
    checkOutput("cf3_pu_stall", pu_stall, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cf4_pu_rvalid", pu_rvalid, 1);
    checkOutput("cf4_hs_rvalid", hs_rvalid, 0);

    // PU-only read of 0xDEADBEEF.
    nextCycle();
    applyStimulus(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("pu_stall", pu_stall, 0);
    checkOutput("pu_m_addr", m_addr, 8'h10);
    checkOutput("pu_m_we", m_we, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pu_rvalid", pu_rvalid, 1);
    checkOutput("pu_rd", pu_rd, 32'hDEADBEEF);
    checkOutput("pu_hs_rvalid", hs_rvalid, 0);

    // Host write, then a host read back of the same word.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 8'h20, 32'h55);
    #1;
    checkOutput("hw_gnt", hs_gnt, 1);
    checkOutput("hw_m_we", m_we, 1);
    checkOutput("hw_m_addr", m_addr, 8'h20);
    checkOutput("hw_m_wd", m_wd, 32'h55);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h20, 0);
    checkOutput("hw_no_rvalid", hs_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hr_rvalid", hs_rvalid, 1);
    checkOutput("hr_rd", hs_rd, 32'h55);

    // Burst limit: host locks alone, PU joins. Four host grants, then the PU.
    nextCycle();
    applyStimulus(0, 0, 8'h03, 0, 1, 0, 1, 8'h04, 0);
    #1;
    checkOutput("bl1_hs_gnt", hs_gnt, 1);
    for (int i = 2; i <= 4; i++) begin
      nextCycle();
      applyStimulus(1, 0, 8'h03, 0, 1, 0, 1, 8'h04, 0);
      #1;
      checkOutput($sformatf("bl%0d_hs_gnt", i), hs_gnt, 1);
      checkOutput($sformatf("bl%0d_pu_stall", i), pu_stall, 1);
    end
    nextCycle();
    checkOutput("bl5_hs_gnt", hs_gnt, 0);
    checkOutput("bl5_pu_stall", pu_stall, 0);
    checkOutput("bl5_m_addr", m_addr, 8'h03);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Early lock release after two grants: the release cycle goes to the PU.
    nextCycle();
    applyStimulus(0, 0, 8'h05, 0, 1, 0, 1, 8'h06, 0);
    nextCycle();
    applyStimulus(1, 0, 8'h05, 0, 1, 0, 1, 8'h06, 0);
    #1;
    checkOutput("er2_hs_gnt", hs_gnt, 1);
    nextCycle();
    applyStimulus(1, 0, 8'h05, 0, 1, 0, 0, 8'h06, 0);
    #1;
    checkOutput("er3_hs_gnt", hs_gnt, 0);
    checkOutput("er3_pu_stall", pu_stall, 0);
    nextCycle();
    checkOutput("er4_hs_gnt", hs_gnt, 1);
    checkOutput("er4_pu_stall", pu_stall, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in LOCK after two grants.
    nextCycle();
    applyStimulus(0, 0, 8'h07, 0, 1, 0, 1, 8'h08, 0);
    nextCycle();
    applyStimulus(1, 0, 8'h07, 0, 1, 0, 1, 8'h08, 0);
    nextCycle();
    applyStimulus(1, 0, 8'h07, 0, 1, 1, 1, 8'h08, 32'h77);
    #1;
    checkOutput("ar_pre_hs_gnt", hs_gnt, 1);
    checkOutput("ar_pre_m_we", m_we, 1);
    checkOutput("ar_pre_hs_rvalid", hs_rvalid, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("ar_hs_gnt", hs_gnt, 0);
    checkOutput("ar_m_we", m_we, 0);
    checkOutput("ar_pu_stall", pu_stall, 1);
    checkOutput("ar_hs_rvalid", hs_rvalid, 0);
    checkOutput("ar_hs_rd", hs_rd, 0);
    nextCycle();
    applyStimulus(1, 0, 8'h07, 0, 1, 0, 0, 8'h08, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("ar_post_hs_gnt", hs_gnt, 0);
    checkOutput("ar_post_pu_stall", pu_stall, 0);
    checkOutput("ar_post_pu_rvalid", pu_rvalid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ar_post_pu_rd", pu_rd, 32'hA5000007);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
